ga_issue_unit: RTL and testbench
================================

Name: ga_issue_unit

Overview:
- Sits between the Ibex core's ID/EX stage and ga_coprocessor, directly upstream of the coprocessor.
- Decodes custom-0 GA instructions and registers a ga_req_t, then runs the valid/busy handshake with the coprocessor.
- Stalls the core until a ga_resp_t arrives or a timeout fires.
- Returns the result to the integer register file as a one-cycle write, or raises an exception.

Parameters:
- TimeoutCycles, 64: cycles to wait for ga_resp.valid after acceptance before declaring a timeout error; minimum 2.
- GAOpcode, 7'b0001011: major opcode decoded as a GA instruction (custom-0).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- instr_valid_i  in  1  ID stage holds a valid instruction this cycle
- instr_i  in  32  instruction word
- rs1_data_i  in  32  integer rs1 operand
- rs2_data_i  in  32  integer rs2 operand
- flush_i  in  1  core pipeline flush/kill
- ga_req_o  out  ga_req_t  request to ga_coprocessor
- ga_resp_i  in  ga_resp_t  response from ga_coprocessor
- stall_o  out  1  hold the ID stage
- rf_we_o  out  1  integer register-file write strobe
- rf_waddr_o  out  5  write address
- rf_wdata_o  out  32  write data
- exc_o  out  1  one-cycle GA exception pulse
- exc_cause_o  out  2  exception cause: 0 = coprocessor error, 1 = timeout, 2 = illegal funct
- issue_count_o  out  32  performance counter; exists only when the optional feature is enabled
- stall_cycles_o  out  32  performance counter; exists only when the optional feature is enabled

Behaviour:
- Decode fields:
  - is_ga = instr_valid_i && instr_i[6:0]==GAOpcode.
  - funct = instr_i[31:25]. Values > GA_FUNCT_MAX are illegal.
  - funct3[0] drives use_ga_regs.
  - funct3[1] drives we: 1 means write the GA register file; no integer writeback.
  - rd, rs1 and rs2 fields map to rd_addr, ga_reg_a and ga_reg_b.
- Reset values: all outputs 0, ga_req_o = '0, state IDLE, counters 0.
- State machine: IDLE, ISSUE, WAIT, WB, ERR.
- IDLE:
  - stall_o = is_ga, combinationally.
  - On is_ga && legal funct && !flush_i: register the request and go to ISSUE.
  - On illegal funct: go to ERR with cause 2.
- ISSUE:
  - ga_req_o.valid = 1; all fields are held stable.
  - Accepted on the first cycle with !ga_resp_i.busy; then clear valid, clear the timeout counter and go to WAIT.
  - flush_i before acceptance: drop the request, go to IDLE, no exception.
- WAIT:
  - Timeout counter increments each cycle.
  - On ga_resp_i.valid:
    - error=1: go to ERR with cause 0.
    - otherwise: latch result and go to WB.
  - Counter reaching TimeoutCycles-1 without valid: go to ERR with cause 1.
  - If valid and timeout occur in the same cycle, valid wins.
  - flush_i in WAIT sets a sticky discard flag. The unit still waits for the response but suppresses writeback and exceptions.
- WB:
  - rf_we_o = !we && !discard && rd!=0, for exactly one cycle.
  - rf_waddr_o = rd; rf_wdata_o = result.
  - stall_o = 0; go to IDLE.
- ERR:
  - exc_o pulses for one cycle with exc_cause_o, unless discard is set.
  - stall_o = 0; go to IDLE.
- stall_o = 1 in ISSUE and WAIT.
- Latency: a GA instruction in IDLE at cycle N produces ga_req_o.valid at N+1. A response at cycle M produces rf_we_o at M+1, and stall_o drops at M+1.
- A response arriving in any state other than WAIT is ignored.
- rd==0 produces no rf_we_o. The unit still stalls and completes the full sequence.
- Asynchronous reset mid-operation returns to IDLE immediately and clears discard and all counters.

Optional Feature:
- Macro GA_ISSUE_PERF_EN.
- Defined:
  - issue_count_o increments on each accepted request.
  - stall_cycles_o increments every cycle stall_o=1.
  - Both counters wrap at 2^32.
- Undefined: the counter logic is not built and both ports are tied to 0.

Decomposition:
- Defined in ga_pkg:
  - GA_FUNCT_MAX.
  - The ga_issue_state_e enum.
  - The ga_exc_cause_e enum (ERROR=0, TIMEOUT=1, ILLEGAL=2).
  - The GA opcode constant.
- ga_req_t, ga_resp_t and ga_funct_e are reused as already defined in ga_pkg.
- One sub-module, ga_issue_decode: purely combinational field extraction and the legality check, instantiated once.

Test Plan:
- ADD, funct3=0, rd=5, rs1=0x3F800000, rs2=0x40000000; coprocessor not busy, responds 3 cycles after acceptance with 0x40400000 -> ga_req_o.valid one cycle; rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x40400000 on the cycle after response; stall_o high throughout until then.
- ga_resp_i.busy held high for 4 cycles -> ga_req_o held valid with fields unchanged for 5 cycles, and accepted on the 5th.
- No response, TimeoutCycles=8 -> exc_o pulse with cause 1 exactly 8 cycles after acceptance; no rf_we_o.
- Response with error=1 -> exc_o with cause 0; no writeback. Illegal funct 0x7F -> exc_o with cause 2; ga_req_o.valid never asserted.
- flush_i while in WAIT, response later -> no rf_we_o, no exc_o, return to IDLE. flush_i while in ISSUE and busy -> request dropped, state IDLE.
- rst_ni pulsed low while in WAIT -> all outputs 0 immediately. With GA_ISSUE_PERF_EN, 3 back-to-back ops -> issue_count_o=3.

Source files
------------

// File: rtl/ga_pkg.sv
// rtl/ga_pkg.sv - GA coprocessor request/response types and issue-unit constants
package ga_pkg;

  localparam logic [6:0] GA_OPCODE = 7'b0001011;

  typedef enum logic [6:0] {
    GA_ADD   = 7'd0,
    GA_SUB   = 7'd1,
    GA_MUL   = 7'd2,
    GA_WEDGE = 7'd3,
    GA_DOT   = 7'd4,
    GA_REV   = 7'd5,
    GA_DUAL  = 7'd6,
    GA_NORM  = 7'd7
  } ga_funct_e;

  localparam logic [6:0] GA_FUNCT_MAX = 7'd7;

  typedef struct packed {
    logic        valid;
    ga_funct_e   funct;
    logic        use_ga_regs;
    logic        we;
    logic [4:0]  rd_addr;
    logic [4:0]  ga_reg_a;
    logic [4:0]  ga_reg_b;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
  } ga_req_t;

  typedef struct packed {
    logic        valid;
    logic        busy;
    logic        error;
    logic [31:0] result;
  } ga_resp_t;

  typedef enum logic [2:0] {
    GA_ST_IDLE,
    GA_ST_ISSUE,
    GA_ST_WAIT,
    GA_ST_WB,
    GA_ST_ERR
  } ga_issue_state_e;

  typedef enum logic [1:0] {
    GA_EXC_ERROR   = 2'd0,
    GA_EXC_TIMEOUT = 2'd1,
    GA_EXC_ILLEGAL = 2'd2
  } ga_exc_cause_e;

  function automatic logic ga_funct_legal(input logic [6:0] funct);
    return funct <= GA_FUNCT_MAX;
  endfunction

endpackage

// File: rtl/ga_issue_unit_decode.sv
// rtl/ga_issue_unit_decode.sv - combinational custom-0 GA field extraction and legality check
module ga_issue_decode
  import ga_pkg::*;
#(
  parameter logic [6:0] GAOpcode = GA_OPCODE
) (
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        is_ga,
  output logic        legal,
  output logic [6:0]  funct,
  output logic        use_ga_regs,
  output logic        we,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  logic unused_funct3_msb;

  assign is_ga       = instr_valid && (instr[6:0] == GAOpcode);
  assign funct       = instr[31:25];
  assign legal       = ga_funct_legal(funct);
  assign use_ga_regs = instr[12];
  assign we          = instr[13];
  assign rd          = instr[11:7];
  assign rs1         = instr[19:15];
  assign rs2         = instr[24:20];

  assign unused_funct3_msb = instr[14];

endmodule

// File: rtl/ga_issue_unit.sv
// rtl/ga_issue_unit.sv - GA instruction issue/stall/writeback unit in front of ga_coprocessor
// Optional performance counters built only when GA_ISSUE_PERF_EN is defined.
module ga_issue_unit
  import ga_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 64,
  parameter logic [6:0]  GAOpcode      = GA_OPCODE
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        flush_i,
  output ga_req_t     ga_req_o,
  input  ga_resp_t    ga_resp_i,
  output logic        stall_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        exc_o,
  output logic [1:0]  exc_cause_o,
  output logic [31:0] issue_count_o,
  output logic [31:0] stall_cycles_o
);

  localparam int unsigned   CntW    = $clog2(TimeoutCycles + 1);
  // Timeout fires when the counter increments onto TimeoutCycles-1, so ERR lands TimeoutCycles after acceptance
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 2);

  ga_issue_state_e state_q, state_d;
  ga_exc_cause_e   cause_q, cause_d;
  ga_req_t         req_q;
  logic [31:0]     result_q;
  logic [CntW-1:0] cnt_q;
  logic            discard_q;
  logic            accept;

  logic       is_ga, legal, use_ga_regs, we;
  logic [6:0] funct;
  logic [4:0] rd, rs1, rs2;

  ga_issue_decode #(
    .GAOpcode(GAOpcode)
  ) u_decode (
    .instr_valid(instr_valid_i),
    .instr      (instr_i),
    .is_ga      (is_ga),
    .legal      (legal),
    .funct      (funct),
    .use_ga_regs(use_ga_regs),
    .we         (we),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2)
  );

  assign accept = (state_q == GA_ST_ISSUE) && !flush_i && !ga_resp_i.busy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= GA_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      GA_ST_IDLE: begin
        if (is_ga && !flush_i) begin
          if (legal) begin
            state_d = GA_ST_ISSUE;
          end else begin
            state_d = GA_ST_ERR;
            cause_d = GA_EXC_ILLEGAL;
          end
        end
      end
      GA_ST_ISSUE: begin
        if (flush_i) begin
          state_d = GA_ST_IDLE;
        end else if (!ga_resp_i.busy) begin
          state_d = GA_ST_WAIT;
        end
      end
      GA_ST_WAIT: begin
        // A response in the same cycle as the timeout still counts
        if (ga_resp_i.valid) begin
          if (ga_resp_i.error) begin
            state_d = GA_ST_ERR;
            cause_d = GA_EXC_ERROR;
          end else begin
            state_d = GA_ST_WB;
          end
        end else if (cnt_q == CntLast) begin
          state_d = GA_ST_ERR;
          cause_d = GA_EXC_TIMEOUT;
        end
      end
      GA_ST_WB:  state_d = GA_ST_IDLE;
      GA_ST_ERR: state_d = GA_ST_IDLE;
      default:   state_d = GA_ST_IDLE;
    endcase
  end

  always_comb begin
    stall_o     = 1'b0;
    rf_we_o     = 1'b0;
    rf_waddr_o  = '0;
    rf_wdata_o  = '0;
    exc_o       = 1'b0;
    exc_cause_o = '0;
    unique case (state_q)
      GA_ST_IDLE:  stall_o = is_ga;
      GA_ST_ISSUE: stall_o = 1'b1;
      GA_ST_WAIT:  stall_o = 1'b1;
      GA_ST_WB: begin
        rf_we_o    = !req_q.we && !discard_q && (req_q.rd_addr != 5'd0);
        rf_waddr_o = req_q.rd_addr;
        rf_wdata_o = result_q;
      end
      GA_ST_ERR: begin
        exc_o       = !discard_q;
        exc_cause_o = discard_q ? 2'd0 : cause_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q     <= '0;
      result_q  <= '0;
      cause_q   <= GA_EXC_ERROR;
      cnt_q     <= '0;
      discard_q <= 1'b0;
    end else begin
      cause_q <= cause_d;
      unique case (state_q)
        GA_ST_IDLE: begin
          discard_q <= 1'b0;
          if (is_ga && legal && !flush_i) begin
            req_q.valid       <= 1'b1;
            req_q.funct       <= ga_funct_e'(funct);
            req_q.use_ga_regs <= use_ga_regs;
            req_q.we          <= we;
            req_q.rd_addr     <= rd;
            req_q.ga_reg_a    <= rs1;
            req_q.ga_reg_b    <= rs2;
            req_q.rs1_data    <= rs1_data_i;
            req_q.rs2_data    <= rs2_data_i;
          end
        end
        GA_ST_ISSUE: begin
          cnt_q <= '0;
          if (accept || flush_i) begin
            req_q.valid <= 1'b0;
          end
        end
        GA_ST_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // Flushed ops still drain the coprocessor but must not retire
          discard_q <= discard_q | flush_i;
          if (ga_resp_i.valid) begin
            result_q <= ga_resp_i.result;
          end
        end
        default: ;
      endcase
    end
  end

  assign ga_req_o = req_q;

`ifdef GA_ISSUE_PERF_EN
  logic [31:0] issue_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept) begin
        issue_cnt_q <= issue_cnt_q + 32'd1;
      end
      if (stall_o) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign issue_count_o  = issue_cnt_q;
  assign stall_cycles_o = stall_cnt_q;
`else
  assign issue_count_o  = '0;
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_ga_issue_unit.sv
// tb/tb_ga_issue_unit.sv - directed self-checking bench for ga_issue_unit
module tb_ga_issue_unit;
  import ga_pkg::*;

  localparam int T = 8;
`ifdef GA_ISSUE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    int          funct;
    int          f3;
    int          rd;
    int          ra;
    int          rb;
    logic [31:0] a;
    logic [31:0] b;
    int          busy;
    int          d;
    bit          err;
    logic [31:0] res;
    int          fl;
  } sc_t;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  ga_req_t     req;
  ga_resp_t    resp;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        exc;
  logic [1:0]  exc_cause;
  logic [31:0] issue_count;
  logic [31:0] stall_cycles;

  ga_issue_unit #(
    .TimeoutCycles(T),
    .GAOpcode     (7'b0001011)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .instr_valid_i (instr_valid),
    .instr_i       (instr),
    .rs1_data_i    (rs1_data),
    .rs2_data_i    (rs2_data),
    .flush_i       (flush),
    .ga_req_o      (req),
    .ga_resp_i     (resp),
    .stall_o       (stall),
    .rf_we_o       (rf_we),
    .rf_waddr_o    (rf_waddr),
    .rf_wdata_o    (rf_wdata),
    .exc_o         (exc),
    .exc_cause_o   (exc_cause),
    .issue_count_o (issue_count),
    .stall_cycles_o(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cur_c = -1;
  int sc_id = -1;

  bit          chk = 1'b0;
  bit          e_rst, e_stall, e_valid, e_we, e_exc;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;
  logic [1:0]  e_cause;
  logic [87:0] e_fields;
  logic [31:0] e_issue, e_scnt;
  int          stall_total = 0;
  int          issue_total = 0;

  int          obs_we_c, obs_exc_c, obs_valid_n;
  logic [31:0] obs_wdata;
  logic [1:0]  obs_cause;

  sc_t sc[$];

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s scenario %0d cycle %0d: got %0h expected %0h", name, sc_id, cur_c, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      cmp("stall", stall, e_stall);
      cmp("req_valid", req.valid, e_valid);
      if (e_valid)
        cmp("req_fields", {req.funct, req.use_ga_regs, req.we, req.rd_addr, req.ga_reg_a,
                           req.ga_reg_b, req.rs1_data, req.rs2_data}, e_fields);
      if (e_rst) cmp("req_zero", req, '0);
      cmp("rf_we", rf_we, e_we);
      if (e_we) begin
        cmp("rf_waddr", rf_waddr, e_waddr);
        cmp("rf_wdata", rf_wdata, e_wdata);
      end
      cmp("exc", exc, e_exc);
      if (e_exc) cmp("exc_cause", exc_cause, e_cause);
      cmp("issue_count", issue_count, e_issue);
      cmp("stall_cycles", stall_cycles, e_scnt);
      if (req.valid) obs_valid_n++;
      if (rf_we && obs_we_c < 0) begin
        obs_we_c  = cur_c;
        obs_wdata = rf_wdata;
      end
      if (exc && obs_exc_c < 0) begin
        obs_exc_c = cur_c;
        obs_cause = exc_cause;
      end
    end
  end

  function automatic sc_t mk(int funct, int f3, int rd, int ra, int rb, logic [31:0] a,
                             logic [31:0] b, int busy, int d, bit err, logic [31:0] res, int fl);
    sc_t s;
    s.funct = funct; s.f3 = f3; s.rd = rd; s.ra = ra; s.rb = rb; s.a = a; s.b = b;
    s.busy = busy; s.d = d; s.err = err; s.res = res; s.fl = fl;
    return s;
  endfunction

  // Timeline model: cycle 0 presents the instruction; everything else follows from latencies.
  task automatic run(input int id, input int max_c);
    sc_t  s;
    bit   illegal, dropped, has_resp, discard, we_ok, exc_any;
    int   a_cyc, m_cyc, e_cyc, last;
    logic [1:0] kind;
    logic [6:0] fn;
    logic [2:0] f3;
    logic [4:0] rd, ra, rb;
    s        = sc[id];
    fn       = 7'(s.funct);
    f3       = 3'(s.f3);
    rd       = 5'(s.rd);
    ra       = 5'(s.ra);
    rb       = 5'(s.rb);
    illegal  = s.funct > 7;
    a_cyc    = 1 + s.busy;
    dropped  = !illegal && s.fl >= 1 && s.fl <= a_cyc;
    has_resp = s.d != 0;
    m_cyc    = a_cyc + s.d;
    if (illegal) e_cyc = 1;
    else if (dropped) e_cyc = s.fl;
    else if (has_resp) e_cyc = m_cyc + 1;
    else e_cyc = a_cyc + T;
    discard  = !illegal && !dropped && s.fl > a_cyc && s.fl < e_cyc;
    we_ok    = !illegal && !dropped && has_resp && !s.err && !f3[1] && !discard && rd != 0;
    exc_any  = illegal || (!dropped && (!has_resp || s.err));
    kind     = illegal ? 2'd2 : (!has_resp ? 2'd1 : 2'd0);
    obs_we_c = -1; obs_exc_c = -1; obs_valid_n = 0;
    last     = (max_c < e_cyc + 1) ? max_c : e_cyc + 1;
    for (int c = 0; c <= last; c++) begin
      @(posedge clk); #1;
      sc_id       = id;
      cur_c       = c;
      instr_valid = (c == 0);
      instr       = {fn, rb, ra, f3, rd, 7'b0001011};
      rs1_data    = s.a;
      rs2_data    = s.b;
      flush       = (c == s.fl);
      resp.busy   = (c >= 1 && c <= s.busy);
      resp.valid  = (has_resp && c == m_cyc) || (c == e_cyc + 1);
      resp.error  = s.err && c == m_cyc;
      resp.result = (c == e_cyc + 1) ? 32'hDEADBEEF : s.res;
      e_rst       = 1'b0;
      e_stall     = (c == 0) || (!illegal && c >= 1 && (dropped ? c <= e_cyc : c < e_cyc));
      e_valid     = !illegal && c >= 1 && c <= (dropped ? e_cyc : a_cyc);
      e_fields    = {fn, f3[0], f3[1], rd, ra, rb, s.a, s.b};
      e_we        = we_ok && c == e_cyc;
      e_waddr     = rd;
      e_wdata     = s.res;
      e_exc       = exc_any && !discard && c == e_cyc;
      e_cause     = kind;
      e_issue     = PERF ? 32'(issue_total) : 32'd0;
      e_scnt      = PERF ? 32'(stall_total) : 32'd0;
      chk         = 1'b1;
      if (e_stall) stall_total++;
      if (!illegal && !dropped && c == a_cyc) issue_total++;
    end
  endtask

  initial begin
    rst_n = 1'b1;
    instr_valid = 1'b0; instr = '0; rs1_data = '0; rs2_data = '0; flush = 1'b0; resp = '0;
    e_rst = 1'b1; e_stall = 0; e_valid = 0; e_we = 0; e_exc = 0;
    e_waddr = '0; e_wdata = '0; e_cause = '0; e_fields = '0; e_issue = '0; e_scnt = '0;
    sc.push_back(mk(0, 0, 5, 1, 2, 32'h3F800000, 32'h40000000, 0, 3, 0, 32'h40400000, -1));
    sc.push_back(mk(2, 1, 7, 3, 4, 32'h11111111, 32'h22222222, 4, 2, 0, 32'h12345678, -1));
    sc.push_back(mk(1, 0, 3, 5, 6, 32'h0000000A, 32'h0000000B, 0, 0, 0, 32'h0, -1));
    sc.push_back(mk(3, 0, 4, 7, 8, 32'h33333333, 32'h44444444, 0, 2, 1, 32'hCAFEF00D, -1));
    sc.push_back(mk(127, 0, 9, 1, 1, 32'h1, 32'h2, 0, 0, 0, 32'h0, -1));
    sc.push_back(mk(8, 0, 9, 2, 2, 32'h1, 32'h2, 0, 0, 0, 32'h0, -1));
    sc.push_back(mk(4, 0, 6, 2, 3, 32'h55555555, 32'h66666666, 0, 4, 0, 32'hABCD0123, 2));
    sc.push_back(mk(5, 0, 10, 4, 5, 32'h77777777, 32'h88888888, 3, 2, 0, 32'h99999999, 2));
    sc.push_back(mk(6, 0, 0, 6, 7, 32'hAAAAAAAA, 32'hBBBBBBBB, 0, 1, 0, 32'h0F0F0F0F, -1));
    sc.push_back(mk(7, 2, 12, 8, 9, 32'hCCCCCCCC, 32'hDDDDDDDD, 0, 2, 0, 32'hF0F0F0F0, -1));
    sc.push_back(mk(0, 1, 13, 10, 11, 32'h01020304, 32'h05060708, 0, 7, 0, 32'h0BADF00D, -1));
    sc.push_back(mk(0, 0, 1, 1, 2, 32'h3F800000, 32'h3F800000, 0, 1, 0, 32'h40000000, -1));
    sc.push_back(mk(2, 0, 2, 3, 4, 32'h40000000, 32'h40400000, 1, 2, 0, 32'h40C00000, -1));
    sc.push_back(mk(4, 0, 3, 5, 6, 32'h40800000, 32'h40A00000, 0, 3, 0, 32'h41A00000, -1));

    #1 rst_n = 1'b0;
    chk = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    e_rst = 1'b0;

    for (int i = 0; i <= 10; i++) begin
      run(i, 1000);
      case (i)
        0: begin
          cmp("pin_add_we_cycle", 128'(obs_we_c), 128'd5);
          cmp("pin_add_wdata", obs_wdata, 32'h40400000);
        end
        1: cmp("pin_busy_valid_cycles", 128'(obs_valid_n), 128'd5);
        2: begin
          cmp("pin_timeout_cycle", 128'(obs_exc_c), 128'd9);
          cmp("pin_timeout_cause", obs_cause, 2'd1);
        end
        3: cmp("pin_error_cause", obs_cause, 2'd0);
        4: begin
          cmp("pin_illegal_cause", obs_cause, 2'd2);
          cmp("pin_illegal_no_valid", 128'(obs_valid_n), 128'd0);
        end
        6: cmp("pin_flush_wait_no_exc", 128'(obs_exc_c), -128'sd1);
        default: ;
      endcase
    end

    // Asynchronous reset while the timeout op sits in WAIT
    run(2, 3);
    @(posedge clk); #1;
    rst_n = 1'b0; instr_valid = 1'b0; flush = 1'b0; resp = '0;
    cur_c = -1; e_rst = 1'b1; e_stall = 0; e_valid = 0; e_we = 0; e_exc = 0;
    stall_total = 0; issue_total = 0; e_issue = '0; e_scnt = '0;
    @(posedge clk); #1;
    rst_n = 1'b1; e_rst = 1'b0;

    for (int i = 11; i <= 13; i++) run(i, 1000);
    @(negedge clk);
    cmp("pin_perf_issue", issue_count, PERF ? 32'd3 : 32'd0);

    @(posedge clk); #1;
    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
